// File: rtl/count_game_pkg.sv
// Shared types and constants for the count-to-target game controller.
//   game_state_e : turn controller states
//   CODE_*       : nibble codes understood by the 4-digit display renderer
//   LFSR_SEED    : reset value of the random step generator
//   max_u        : elaboration-time helper for derived widths
package count_game_pkg;

    typedef enum logic [1:0] {
        START   = 2'd0,
        P_TURN  = 2'd1,
        C_THINK = 2'd2,
        RESULT  = 2'd3
    } game_state_e;

    localparam logic [3:0] CODE_L   = 4'hA;
    localparam logic [3:0] CODE_W1  = 4'hB;
    localparam logic [3:0] CODE_W2  = 4'hC;
    localparam logic [3:0] CODE_E   = 4'hD;
    localparam logic [3:0] CODE_N   = 4'hE;
    localparam logic [3:0] CODE_OFF = 4'hF;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used for the
// computer's random step. Advances every cycle; seeded non-zero so it never
// reaches the all-zero lock-up state.
//   clk     : system clock
//   reset_n : asynchronous active-low reset, loads LFSR_SEED
//   state_o : current LFSR state
module game_lfsr8
    import count_game_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] state_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Feedback from taps 8,6,5,4 shifted in at the low end.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/count_game_ctrl.sv
// Turn controller for the count-to-target game. Players add 1..MAX_STEP to a
// running total; whoever brings it to TARGET or beyond loses. Handles button
// synchronisation/edge detection, the computer opponent (random or optimal),
// turn timing and the result display.
//   clk, reset_n : clock, asynchronous active-low reset
//   btn          : raw step buttons, bit i adds i+1
//   mode_opt     : 1 = optimal computer (sampled at game start)
//   comp_first   : 1 = computer opens (sampled at game start)
//   total        : running total
//   comp_step    : last computer step, 0 before its first move
//   game_over    : high while the result is shown
//   player_win   : result, valid while game_over
//   disp         : four display nibble codes, digit 0 in [3:0]
module count_game_ctrl
    import count_game_pkg::*;
#(
    parameter int unsigned TARGET        = 31,
    parameter int unsigned MAX_STEP      = 3,
    parameter int unsigned THINK_CYCLES  = 200_000_000,
    parameter int unsigned RESULT_CYCLES = 200_000_000,
    parameter int unsigned TW            = $clog2(TARGET + MAX_STEP)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [MAX_STEP-1:0] btn,
    input  logic                mode_opt,
    input  logic                comp_first,
    output logic [TW-1:0]       total,
    output logic [2:0]          comp_step,
    output logic                game_over,
    output logic                player_win,
    output logic [15:0]         disp
);

    localparam int unsigned TMR_W = max_u(1, $clog2(max_u(THINK_CYCLES, RESULT_CYCLES)));

    localparam logic [TW-1:0]    TARGET_T    = TW'(TARGET);
    localparam logic [TMR_W-1:0] THINK_LAST  = TMR_W'(THINK_CYCLES - 1);
    localparam logic [TMR_W-1:0] RESULT_LAST = TMR_W'(RESULT_CYCLES - 1);

    game_state_e         state_q, state_d;
    logic [TW-1:0]       total_q, total_d;
    logic [2:0]          comp_step_q, comp_step_d;
    logic                game_over_q, game_over_d;
    logic                player_win_q, player_win_d;
    logic                opt_q, opt_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;

    logic [MAX_STEP-1:0] sync1_q, sync2_q, prev_q;
    logic [MAX_STEP-1:0] press;
    logic                press_any;
    logic [2:0]          press_step;

    logic [7:0]          lfsr;
    logic [2:0]          rand_step;
    logic [2:0]          opt_raw;
    logic [2:0]          comp_pick;
    logic [TW-1:0]       sum_player;
    logic [TW-1:0]       sum_comp;
    logic [3:0]          tens, ones;

    game_lfsr8 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .state_o (lfsr)
    );

    // Two-flop synchroniser followed by rising-edge detect, so a held button counts once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press = sync2_q & ~prev_q;

    // Priority pick: scanning downwards leaves the lowest pressed index.
    always_comb begin
        press_any  = 1'b0;
        press_step = 3'd0;
        for (int i = int'(MAX_STEP) - 1; i >= 0; i--) begin
            if (press[i]) begin
                press_any  = 1'b1;
                press_step = 3'(i + 1);
            end
        end
    end

    // Computer step: optimal leaves the total at TARGET-1 modulo MAX_STEP+1;
    // from a losing position (raw 0) fall back to a random step.
    assign rand_step = 3'(32'(lfsr) % MAX_STEP) + 3'd1;
    assign opt_raw   = 3'((TARGET - 1 - 32'(total_q)) % (MAX_STEP + 1));
    assign comp_pick = (opt_q && (opt_raw != 3'd0)) ? opt_raw : rand_step;

    assign sum_player = total_q + TW'(press_step);
    assign sum_comp   = total_q + TW'(comp_pick);

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        comp_step_d  = comp_step_q;
        game_over_d  = game_over_q;
        player_win_d = player_win_q;
        opt_d        = opt_q;
        tmr_d        = tmr_q;

        case (state_q)
            START: begin
                opt_d        = mode_opt;
                total_d      = '0;
                comp_step_d  = 3'd0;
                game_over_d  = 1'b0;
                player_win_d = 1'b0;
                tmr_d        = '0;
                state_d      = comp_first ? C_THINK : P_TURN;
            end
            P_TURN: begin
                if (press_any) begin
                    total_d = sum_player;
                    tmr_d   = '0;
                    if (sum_player >= TARGET_T) begin
                        state_d      = RESULT;
                        game_over_d  = 1'b1;
                        player_win_d = 1'b0;
                    end else begin
                        state_d = C_THINK;
                    end
                end
            end
            C_THINK: begin
                if (tmr_q == THINK_LAST) begin
                    total_d     = sum_comp;
                    comp_step_d = comp_pick;
                    tmr_d       = '0;
                    if (sum_comp >= TARGET_T) begin
                        state_d      = RESULT;
                        game_over_d  = 1'b1;
                        player_win_d = 1'b1;
                    end else begin
                        state_d = P_TURN;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            RESULT: begin
                // Clear on exit so START already shows an empty board.
                if (tmr_q == RESULT_LAST) begin
                    state_d      = START;
                    tmr_d        = '0;
                    total_d      = '0;
                    comp_step_d  = 3'd0;
                    game_over_d  = 1'b0;
                    player_win_d = 1'b0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= START;
            total_q      <= '0;
            comp_step_q  <= 3'd0;
            game_over_q  <= 1'b0;
            player_win_q <= 1'b0;
            opt_q        <= 1'b0;
            tmr_q        <= '0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            comp_step_q  <= comp_step_d;
            game_over_q  <= game_over_d;
            player_win_q <= player_win_d;
            opt_q        <= opt_d;
            tmr_q        <= tmr_d;
        end
    end

    // Display is a pure decode of registered state, so it changes once per cycle.
    assign tens = 4'(32'(total_q) / 32'd10);
    assign ones = 4'(32'(total_q) % 32'd10);

    always_comb begin
        disp = {ones, tens, CODE_OFF, CODE_OFF};
        if (state_q == RESULT) begin
            if (player_win_q) begin
                disp = {CODE_N, 4'h1, CODE_W2, CODE_W1};
            end else begin
                disp = {CODE_E, 4'h5, 4'h0, CODE_L};
            end
        end
    end

    assign total      = total_q;
    assign comp_step  = comp_step_q;
    assign game_over  = game_over_q;
    assign player_win = player_win_q;

endmodule

// File: tb/tb_count_game_ctrl.sv
// Randomised bench for count_game_ctrl. The driver plays games at transaction
// level, predicting every visible output change (cycle, total, computer step,
// result, display) from the game rules and queueing it; the monitor pops and
// compares whenever the DUT's visible state changes.
module tb_count_game_ctrl;

    localparam int unsigned TARGET   = 31;
    localparam int unsigned MAX_STEP = 3;
    localparam int unsigned THINK    = 4;
    localparam int unsigned RESULT   = 8;
    localparam int unsigned TW       = $clog2(TARGET + MAX_STEP);

    logic                clk = 1'b0;
    logic                reset_n = 1'b1;
    logic [MAX_STEP-1:0] btn = '0;
    logic                mode_opt = 1'b0;
    logic                comp_first = 1'b0;
    logic [TW-1:0]       total;
    logic [2:0]          comp_step;
    logic                game_over;
    logic                player_win;
    logic [15:0]         disp;

    count_game_ctrl #(
        .TARGET        (TARGET),
        .MAX_STEP      (MAX_STEP),
        .THINK_CYCLES  (THINK),
        .RESULT_CYCLES (RESULT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn        (btn),
        .mode_opt   (mode_opt),
        .comp_first (comp_first),
        .total      (total),
        .comp_step  (comp_step),
        .game_over  (game_over),
        .player_win (player_win),
        .disp       (disp)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; edge k is the k-th posedge with reset_n high.
    int cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        int          cyc;
        int          total;
        int          step;
        bit          over;
        bit          win;
        logic [15:0] disp;
    } exp_t;

    exp_t q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Game model owned by the driver.
    int m_total  = 0;
    int m_step   = 0;
    bit m_opt    = 1'b0;
    int t_turn   = 0;
    int last_rel = 0;
    int games    = 0;

    // Side-channel requests to the checker.
    logic chk_pulse = 1'b0;
    int   chk_kind  = 0;
    bit   mon_en    = 1'b0;

    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] s;
        s = 8'hA5;
        for (int k = 0; k < n; k++) s = {s[6:0], ^(s & 8'hB8)};
        return s;
    endfunction

    function automatic logic [15:0] disp_of(input int t, input bit over, input bit win);
        if (over) return win ? 16'hE1CB : 16'hD50A;
        return {4'(t % 10), 4'(t / 10), 8'hFF};
    endfunction

    task automatic push_exp(input int c, input int t, input int s, input bit over, input bit win);
        exp_t e;
        e.cyc   = c;
        e.total = t;
        e.step  = s;
        e.over  = over;
        e.win   = win;
        e.disp  = disp_of(t, over, win);
        q.push_back(e);
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Computer opens its think period at edge t0 and moves THINK edges later.
    task automatic comp_move(input int t0);
        int c, r, s;
        bit over;
        c = t0 + int'(THINK);
        r = int'(lfsr_after(c - 1)) % int'(MAX_STEP) + 1;
        s = (int'(TARGET) - 1 - m_total) % (int'(MAX_STEP) + 1);
        if (!m_opt || s == 0) s = r;
        m_total += s;
        m_step   = s;
        over     = (m_total >= int'(TARGET));
        push_exp(c, m_total, s, over, 1'b1);
        if (over) finish_game(c);
        else      t_turn = c;
    endtask

    // Game leaves START at edge s.
    task automatic start_game(input int s);
        m_opt = mode_opt;
        if (comp_first) comp_move(s);
        else            t_turn = s;
    endtask

    // Game ended at edge e: board clears RESULT edges later, new game one edge after.
    task automatic finish_game(input int e);
        games++;
        push_exp(e + int'(RESULT), 0, 0, 1'b0, 1'b0);
        m_total    = 0;
        m_step     = 0;
        mode_opt   = 1'($urandom_range(0, 1));
        comp_first = 1'($urandom_range(0, 1));
        start_game(e + int'(RESULT) + 1);
    endtask

    task automatic player_move(input logic [MAX_STEP-1:0] mask, input int hold, output bit over);
        int p, step;
        logic [MAX_STEP-1:0] m;
        p = t_turn - 2 + int'($urandom_range(0, 3));
        if (p <= last_rel) p = last_rel + 1;
        if (p < cyc) p = cyc;
        wait_edge(p);
        btn  = mask;
        m    = mask;
        step = 0;
        for (int k = 0; k < int'(MAX_STEP); k++) begin
            if (m[k] && step == 0) step = k + 1;
        end
        m_total += step;
        over = (m_total >= int'(TARGET));
        push_exp(p + 3, m_total, m_step, over, 1'b0);
        if (over) finish_game(p + 3);
        else      comp_move(p + 3);
        wait_edge(p + hold);
        btn      = '0;
        last_rel = p + hold;
    endtask

    // A press whose edge lands outside P_TURN; it must leave no trace.
    task automatic dead_press(input logic [MAX_STEP-1:0] mask, input int hold);
        int p;
        p   = cyc;
        btn = mask;
        wait_edge(p + hold);
        btn      = '0;
        last_rel = p + hold;
    endtask

    task automatic check_val(input string name, input int act, input int want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, want, want);
    endtask

    // Checker: reacts to visible output changes, plus explicit requests from the driver.
    int   p_total, p_step;
    bit   p_over;
    exp_t ce;
    always @(negedge clk or posedge chk_pulse) begin
        if (chk_pulse) begin
            if (chk_kind == 1) begin
                check_val("reset_total",      int'(total),      0);
                check_val("reset_comp_step",  int'(comp_step),  0);
                check_val("reset_game_over",  int'(game_over),  0);
                check_val("reset_player_win", int'(player_win), 0);
                check_val("reset_disp",       int'(disp),       32'h00FF);
            end else begin
                check_val("pending_events", q.size(), 0);
            end
        end else if (mon_en && reset_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                ce = q.pop_front();
                n_chk++;
                $display("FAIL missed_event: expected at cyc %0d total=%0d step=%0d, now cyc %0d total=%0d",
                         ce.cyc, ce.total, ce.step, cyc, total);
            end
            if (int'(total) != p_total || int'(comp_step) != p_step || game_over != p_over) begin
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_event: cyc=%0d total=%0d step=%0d over=%0b",
                             cyc, total, comp_step, game_over);
                end else begin
                    ce = q.pop_front();
                    if (ce.cyc == cyc && ce.total == int'(total) && ce.step == int'(comp_step) &&
                        ce.over == game_over && (!ce.over || ce.win == player_win) && ce.disp == disp) begin
                        n_pass++;
                    end else begin
                        $display("FAIL event: got cyc=%0d total=%0d step=%0d over=%0b win=%0b disp=%h want cyc=%0d total=%0d step=%0d over=%0b win=%0b disp=%h",
                                 cyc, total, comp_step, game_over, player_win, disp,
                                 ce.cyc, ce.total, ce.step, ce.over, ce.win, ce.disp);
                    end
                end
            end
            p_total = int'(total);
            p_step  = int'(comp_step);
            p_over  = game_over;
        end else begin
            p_total = 0;
            p_step  = 0;
            p_over  = 1'b0;
        end
    end

    task automatic request_check(input int kind);
        chk_kind  = kind;
        chk_pulse = 1'b1;
        #1;
        chk_pulse = 1'b0;
    endtask

    initial begin
        bit over;
        logic [MAX_STEP-1:0] mask;

        #2 reset_n = 1'b0;
        #1 request_check(1);
        @(negedge clk);
        #2 reset_n = 1'b1;
        mon_en = 1'b1;
        start_game(1);

        // Held button counts once; simultaneous rises take the lowest index.
        player_move(3'b010, 20, over);
        player_move(3'b101, 3, over);
        if (!over) dead_press(3'b100, 6);

        // Random play over several games, both opponent modes and turn orders.
        while (games < 10 && cyc < 20000) begin
            mask = MAX_STEP'($urandom_range(1, (1 << MAX_STEP) - 1));
            player_move(mask, int'($urandom_range(3, 5)), over);
            if (over && $urandom_range(0, 1) == 1) dead_press(3'b001, 3);
        end

        // Reset in the middle of the computer's think period.
        player_move(3'b001, 3, over);
        wait_edge(cyc + 2);
        @(negedge clk);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1 request_check(1);
        q.delete();
        m_total    = 0;
        m_step     = 0;
        last_rel   = 0;
        comp_first = 1'b1;
        mode_opt   = 1'($urandom_range(0, 1));
        @(negedge clk);
        #2 reset_n = 1'b1;
        mon_en = 1'b1;
        start_game(1);
        player_move(3'b010, 3, over);

        for (int k = 0; k < 300 && q.size() > 0; k++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1 request_check(2);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
